// File: rtl/whac_pkg.sv
// Shared types and constants for the whac-a-mole scoring path.
package whac_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    STREAK = 2'd2,
    BREAK  = 2'd3
  } combo_state_t;

  // Width of the score_counter combo input.
  localparam int COMBO_W           = 7;
  localparam int MAX_COMBO_DEFAULT = 99;

endpackage

// File: rtl/combo_timeout_timer.sv
// Counts idle cycles of an active streak.
// Saturates at COMBO_TIMEOUT-1 and flags expiry unless cleared that cycle.
module combo_timeout_timer #(
  parameter int COMBO_TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TIMER_W = $clog2(COMBO_TIMEOUT);
  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(COMBO_TIMEOUT - 1);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST)) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A hit in the expiry cycle clears the timer, so it must also suppress expiry.
  assign expired = (count_q == LAST) && !clear;

endmodule

// File: rtl/combo_tracker.sv
// Consecutive-hit streak tracker feeding score_counter.
// Provides a saturating combo count, session best and a one-cycle break strobe.
module combo_tracker
  import whac_pkg::*;
#(
  parameter int MAX_COMBO     = MAX_COMBO_DEFAULT,
  parameter int COMBO_TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_active,
  input  logic               hit,
  input  logic               miss,
  output logic [COMBO_W-1:0] combo_count,
  output logic [COMBO_W-1:0] best_combo,
  output logic               combo_break
);

  localparam int CNT_W = $clog2(MAX_COMBO + 1);

  combo_state_t     state_q;
  logic [CNT_W-1:0] combo_q;
  logic [CNT_W-1:0] best_q;
  logic             break_q;

  logic [CNT_W:0]   inc_wide;
  logic [CNT_W-1:0] combo_inc;
  logic             timer_clear;
  logic             timer_expired;

  // Increment one bit wider so the saturation compare cannot wrap.
  assign inc_wide  = {1'b0, combo_q} + (CNT_W + 1)'(1);
  assign combo_inc = (inc_wide > (CNT_W + 1)'(MAX_COMBO)) ? CNT_W'(MAX_COMBO)
                                                          : inc_wide[CNT_W-1:0];

  assign timer_clear = (state_q != STREAK) || hit || !game_active;

  combo_timeout_timer #(
    .COMBO_TIMEOUT(COMBO_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (state_q == STREAK),
    .expired(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      combo_q <= '0;
      best_q  <= '0;
      break_q <= 1'b0;
    end else begin
      break_q <= 1'b0;
      if (!game_active) begin
        state_q <= IDLE;
        combo_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= ARMED;
            combo_q <= '0;
          end
          ARMED: begin
            if (hit && !miss) begin
              state_q <= STREAK;
              combo_q <= combo_inc;
              if (combo_inc > best_q) best_q <= combo_inc;
            end
          end
          STREAK: begin
            if (miss || (!hit && timer_expired)) begin
              state_q <= BREAK;
              combo_q <= '0;
              break_q <= 1'b1;
            end else if (hit) begin
              combo_q <= combo_inc;
              if (combo_inc > best_q) best_q <= combo_inc;
            end
          end
          BREAK: begin
            state_q <= ARMED;
            combo_q <= '0;
          end
          default: begin
            state_q <= IDLE;
            combo_q <= '0;
          end
        endcase
      end
    end
  end

  assign combo_count = COMBO_W'(combo_q);
  assign best_combo  = COMBO_W'(best_q);
  assign combo_break = break_q;

endmodule
